// File: rtl/mem_copy_dma_if.sv
// Single-port word memory bus: byte address, read strobe, registered read data
// and a write path with byte enables.
interface mem_copy_dma_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_rstrb,
    output mem_wdata,
    output mem_wmask,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rstrb,
    input  mem_wdata,
    input  mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-block copy engine acting as a second bus master: one strobed read then
// one full-word write per word, ascending addresses, with abort support.
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  mem_copy_dma_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] rem;

  // Byte-offset bits of the addresses are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      done       <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            words_done <= '0;
            if (len_words == '0) done  <= 1'b1;
            else                 state <= RD;
          end
        end
        RD: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else begin
            state <= WR;
          end
        end
        WR: begin
          words_done <= words_done + LEN_W'(1);
          // The write in this cycle always lands; abort only decides what follows.
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (rem == LEN_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers are only meaningful once a start has loaded them.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          src_ptr <= {src_addr[31:2], 2'b00};
          dst_ptr <= {dst_addr[31:2], 2'b00};
          rem     <= len_words;
        end
      end
      RD: src_ptr <= src_ptr + 32'd4;
      WR: begin
        dst_ptr <= dst_ptr + 32'd4;
        rem     <= rem - LEN_W'(1);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bus.mem_addr  = 32'h0;
    bus.mem_rstrb = 1'b0;
    bus.mem_wmask = 4'h0;
    case (state)
      RD: begin
        bus.mem_addr  = src_ptr;
        bus.mem_rstrb = 1'b1;
      end
      WR: begin
        bus.mem_addr  = dst_ptr;
        bus.mem_wmask = 4'hF;
      end
      default: ;
    endcase
  end

  // Read data is held by the memory until the next strobe, so it passes straight through.
  assign bus.mem_wdata = bus.mem_rdata;

endmodule
